// File: rtl/bcd_arbiter.sv
`default_nettype none
// ============================================================================
// bcd_arbiter : round-robin arbiter sharing one binary-to-BCD converter
//               among NREQ requesters, with a converter-hang timeout.
// Revision    : 1.0
// ============================================================================
module bcd_arbiter #(
  parameter int NREQ    = 3,
  parameter int BIN_W   = 12,
  parameter int BCD_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*BIN_W-1:0] bin_in,
  output logic [NREQ-1:0]       ack,
  output logic [BCD_W-1:0]      bcd_out,
  output logic                  err,
  output logic                  busy,
  output logic                  conv_start,
  output logic [BIN_W-1:0]      conv_bin,
  input  logic [BCD_W-1:0]      conv_bcd,
  input  logic                  conv_done
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_q, gnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             err_q, err_d;

  logic [BIN_W-1:0] ops [NREQ];
  logic [PTR_W:0]   cand;
  logic [PTR_W-1:0] pick;
  logic             found;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
    assign ops[gi] = bin_in[gi*BIN_W +: BIN_W];
  end

  // Scan requesters starting at ptr, wrapping once; first high req wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NREQ)) begin
        cand = cand - (PTR_W+1)'(NREQ);
      end
      if (!found && req[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = pick;
          bin_d   = ops[pick];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the final timeout cycle still counts as success.
        if (conv_done) begin
          bcd_d   = conv_bcd;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          bcd_d   = '1;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        ptr_d   = (gnt_q == PTR_W'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack        = '0;
    busy       = (state_q != S_IDLE);
    conv_start = (state_q == S_ISSUE);
    if (state_q == S_RESP) begin
      ack[gnt_q] = 1'b1;
    end
  end

  assign bcd_out  = bcd_q;
  assign err      = err_q;
  assign conv_bin = bin_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bcd_arbiter : randomized self-checking bench for bcd_arbiter with a
//                  transaction-level round-robin/BCD reference model.
// Revision       : 1.0
// ============================================================================
module tb_bcd_arbiter;

  localparam int NREQ = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [11:0] opnd [NREQ];
  logic [35:0] bin_in;
  logic [2:0]  ack;
  logic [15:0] bcd_out;
  logic        err, busy, conv_start;
  logic [11:0] conv_bin;
  logic [15:0] conv_bcd;
  logic        conv_done, model_done, spur_done;

  int          conv_delay;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_starts = 0;
  int          m_ptr    = 0;
  logic [15:0] last_bcd = 16'h0000;

  logic        pend = 1'b0;
  int          left = 0;
  logic [15:0] res  = 16'h0000;

  assign bin_in    = {opnd[2], opnd[1], opnd[0]};
  assign conv_done = model_done | spur_done;

  bcd_arbiter #(.NREQ(3), .BIN_W(12), .BCD_W(16), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req(req), .bin_in(bin_in), .ack(ack),
    .bcd_out(bcd_out), .err(err), .busy(busy), .conv_start(conv_start),
    .conv_bin(conv_bin), .conv_bcd(conv_bcd), .conv_done(conv_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (conv_start === 1'b1) n_starts <= n_starts + 1;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int rr_pick(input logic [2:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Converter model: done pulses conv_delay cycles after start; 0 means it hangs.
  always @(negedge clk) begin
    model_done <= 1'b0;
    conv_bcd   <= 16'($urandom);
    if (!reset) begin
      pend <= 1'b0;
    end else if (conv_start) begin
      pend <= (conv_delay != 0);
      left <= conv_delay;
      res  <= to_bcd(int'(conv_bin));
    end else if (pend) begin
      if (left == 1) begin
        model_done <= 1'b1;
        conv_bcd   <= res;
        pend       <= 1'b0;
      end
      left <= left - 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One arbitration round; returns at the negedge of the ack cycle.
  task automatic run_txn(input int dly, input bit drop, input bit fresh,
                         input bit spur_issue, output int g_out);
    int g, s_cyc, a_cyc, req_c, base, exp_lat;
    bit ok, good;
    logic [15:0] exp_bcd;
    logic [2:0]  exp_ack;
    g          = rr_pick(req, m_ptr);
    g_out      = g;
    req_c      = cyc;
    base       = n_starts;
    conv_delay = dly;
    if (g < 0) begin
      check_eq("pick_valid", 32'(g), 32'd0);
      return;
    end
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check_eq("ack_pulse", 32'(ack), 32'd0);
        check_eq("bcd_hold", 32'(bcd_out), 32'(last_bcd));
      end
      if (conv_start) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("start_seen", 32'(ok), 32'd1);
    if (!ok) return;
    s_cyc = cyc;
    if (spur_issue) spur_done = 1'b1;
    if (fresh) check_eq("start_latency", 32'(s_cyc - req_c), 32'd1);
    check_eq("conv_bin", 32'(conv_bin), 32'(opnd[g]));
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 0 && spur_issue) begin
        spur_done = 1'b0;
        check_eq("spur_issue_ack", 32'(ack), 32'd0);
        check_eq("spur_issue_hold", 32'(bcd_out), 32'(last_bcd));
      end
      if (ack != 3'b000) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("ack_seen", 32'(ok), 32'd1);
    if (!ok) return;
    a_cyc   = cyc;
    good    = (dly >= 1 && dly <= 64);
    exp_lat = good ? dly + 1 : 65;
    exp_bcd = good ? to_bcd(int'(opnd[g])) : 16'hFFFF;
    exp_ack = 3'b001 << g;
    check_eq("ack_onehot", 32'(ack), 32'(exp_ack));
    check_eq("bcd_out", 32'(bcd_out), 32'(exp_bcd));
    check_eq("err", 32'(err), 32'(!good));
    check_eq("ack_latency", 32'(a_cyc - s_cyc), 32'(exp_lat));
    check_eq("conv_bin_hold", 32'(conv_bin), 32'(opnd[g]));
    check_eq("start_count", 32'(n_starts - base), 32'd1);
    last_bcd = exp_bcd;
    m_ptr    = (g + 1) % NREQ;
    if (drop) req[g] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, prev, r;
    bit ok;
    reset = 1'b0; req = 3'b000; spur_done = 1'b0; conv_delay = 1;
    for (int i = 0; i < NREQ; i++) opnd[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_bcd", 32'(bcd_out), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(conv_start), 32'd0);
    check_eq("rst_conv_bin", 32'(conv_bin), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Simultaneous requests straight after reset.
    opnd[0] = 12'd0; opnd[1] = 12'd4095; opnd[2] = 12'd999;
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      run_txn(5 + i, 1'b1, 1'b0, 1'b0, g);
      check_eq("sim_order", 32'(g), 32'(i));
    end

    @(negedge clk);
    opnd[0] = 12'd189; req = 3'b001;
    run_txn(14, 1'b1, 1'b1, 1'b0, g);

    // Fairness between requesters 0 and 2 that re-request immediately.
    @(negedge clk);
    opnd[0] = 12'($urandom_range(0, 4095)); opnd[2] = 12'($urandom_range(0, 4095));
    req = 3'b101; prev = -1;
    for (int i = 0; i < 4; i++) begin
      run_txn(3, 1'b0, i == 0, 1'b0, g);
      check_eq("fair_not_1", 32'(g == 1), 32'd0);
      if (i > 0) check_eq("fair_alternate", 32'(g != prev), 32'd1);
      prev = g;
    end
    req = 3'b000;

    // Hung converter, done on the last timeout cycle, done one cycle too late.
    @(negedge clk); req = 3'b001; run_txn(0, 1'b1, 1'b1, 1'b0, g);
    @(negedge clk); req = 3'b010; run_txn(64, 1'b1, 1'b1, 1'b0, g);
    @(negedge clk); req = 3'b100; run_txn(65, 1'b1, 1'b1, 1'b0, g);
    @(negedge clk); req = 3'b001; run_txn(3, 1'b1, 1'b1, 1'b0, g);

    // Spurious done in IDLE, then in ISSUE.
    repeat (2) @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check_eq("spur_idle_ack", 32'(ack), 32'd0);
    check_eq("spur_idle_busy", 32'(busy), 32'd0);
    check_eq("spur_idle_hold", 32'(bcd_out), 32'(last_bcd));
    @(negedge clk);
    opnd[1] = 12'($urandom_range(0, 4095)); req = 3'b010;
    run_txn(10, 1'b1, 1'b1, 1'b1, g);

    // Reset while waiting on a hung converter.
    @(negedge clk);
    req = 3'b001; conv_delay = 0; ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (conv_start) begin ok = 1'b1; break; end
    end
    check_eq("rst_wait_start_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_wait_busy", 32'(busy), 32'd0);
    check_eq("rst_wait_start", 32'(conv_start), 32'd0);
    check_eq("rst_wait_ack", 32'(ack), 32'd0);
    check_eq("rst_wait_err", 32'(err), 32'd0);
    check_eq("rst_wait_bcd", 32'(bcd_out), 32'd0);
    req = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b1; m_ptr = 0; last_bcd = 16'h0000;
    @(negedge clk);
    opnd[1] = 12'($urandom_range(0, 4095)); req = 3'b010;
    run_txn(6, 1'b1, 1'b1, 1'b0, g);
    check_eq("rst_served_1", 32'(g), 32'd1);

    // Pointer returns to 0 after a reset taken in IDLE.
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; m_ptr = 0; last_bcd = 16'h0000;
    @(negedge clk);
    req = 3'b101;
    run_txn(3, 1'b1, 1'b1, 1'b0, g);
    check_eq("ptr_after_reset", 32'(g), 32'd0);
    run_txn(4, 1'b1, 1'b0, 1'b0, g);

    // Randomized traffic; new requests are raised in the ack cycle.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          opnd[i] = 12'($urandom_range(0, 4095));
          req[i]  = 1'b1;
        end
      end
      if (req == 3'b000) begin
        r = int'($urandom_range(0, 2));
        opnd[r] = 12'($urandom_range(0, 4095));
        req[r]  = 1'b1;
      end
      r = int'($urandom_range(0, 9));
      case (r)
        0:       conv_delay = 0;
        1:       conv_delay = 64;
        2:       conv_delay = 65;
        3:       conv_delay = 63;
        default: conv_delay = int'($urandom_range(1, 20));
      endcase
      run_txn(conv_delay, 1'b1, 1'b0, 1'b0, g);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
